// File: rtl/adder_ring_counter.sv
// Ring-oscillator edge counter for the instrumented adder: runs the ring for a
// settle period, counts synchronised rising edges of chain_out over a window, and holds the result.
module adder_ring_counter #(
   parameter int COUNT_W       = 32,
   parameter int WIN_W         = 32,
   parameter int SYNC_STAGES   = 2,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic               wb_clk_i,
   input  logic               rst_n,
   input  logic               active,
   input  logic               start,
   input  logic [WIN_W-1:0]   window,
   input  logic               ring_in,
   output logic               ring_en,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] count,
   output logic               overflow
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_COUNT  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [WIN_W-1:0]   WIN_ONE    = WIN_W'(1);
   localparam logic [WIN_W-1:0]   SETTLE_END = WIN_W'(SETTLE_CYCLES - 1);
   localparam logic [COUNT_W-1:0] CNT_ONE    = COUNT_W'(1);

   state_t               state_r;
   state_t               state_nxt_s;
   logic [SYNC_STAGES-1:0] sync_r;
   logic                 ring_prev_r;
   logic                 edge_s;
   logic [WIN_W-1:0]     window_r;
   logic [WIN_W-1:0]     cyc_cnt_r;
   logic [COUNT_W-1:0]   counter_r;
   logic [COUNT_W-1:0]   counter_nxt_s;
   logic                 ovf_int_r;
   logic                 ovf_nxt_s;
   logic                 accept_s;
   logic                 settle_last_s;
   logic                 count_last_s;

   // The edge detector runs in every state, so a level already high on entry to COUNT is not an edge.
   assign edge_s        = sync_r[SYNC_STAGES-1] & ~ring_prev_r;
   assign accept_s      = active & start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
   assign settle_last_s = (cyc_cnt_r == SETTLE_END);
   assign count_last_s  = (cyc_cnt_r == (window_r - WIN_ONE));

   // Synchroniser and edge history for the asynchronous ring output.
   always_ff @(posedge wb_clk_i) begin
      if (!rst_n) begin
         sync_r      <= '0;
         ring_prev_r <= 1'b0;
      end else begin
         sync_r      <= {sync_r[SYNC_STAGES-2:0], ring_in};
         ring_prev_r <= sync_r[SYNC_STAGES-1];
      end
   end

   // Saturating edge counter; an edge arriving at all-ones only flags overflow.
   always_comb begin
      counter_nxt_s = counter_r;
      ovf_nxt_s     = ovf_int_r;
      if ((state_r == ST_COUNT) && edge_s) begin
         if (&counter_r) begin
            ovf_nxt_s = 1'b1;
         end else begin
            counter_nxt_s = counter_r + CNT_ONE;
         end
      end else begin
         counter_nxt_s = counter_r;
      end
   end

   // Next-state logic; dropping active overrides everything, including a same-cycle start.
   always_comb begin
      state_nxt_s = state_r;
      if (!active) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_nxt_s = (window == '0) ? ST_DONE : ST_SETTLE;
               end else begin
                  state_nxt_s = state_r;
               end
            end
            ST_SETTLE: begin
               if (settle_last_s) begin
                  state_nxt_s = ST_COUNT;
               end else begin
                  state_nxt_s = ST_SETTLE;
               end
            end
            ST_COUNT: begin
               if (count_last_s) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_COUNT;
               end
            end
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // State register and control outputs, all decoded from the next state so they are registered.
   always_ff @(posedge wb_clk_i) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         ring_en   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cyc_cnt_r <= '0;
      end else begin
         state_r   <= state_nxt_s;
         ring_en   <= (state_nxt_s == ST_SETTLE) | (state_nxt_s == ST_COUNT);
         busy      <= (state_nxt_s == ST_SETTLE) | (state_nxt_s == ST_COUNT);
         done      <= (state_nxt_s == ST_DONE);
         cyc_cnt_r <= (state_nxt_s == state_r) ? (cyc_cnt_r + WIN_ONE) : '0;
      end
   end

   // Measurement datapath: window latch, running counter and result capture.
   always_ff @(posedge wb_clk_i) begin
      if (!rst_n) begin
         window_r  <= '0;
         counter_r <= '0;
         ovf_int_r <= 1'b0;
         count     <= '0;
         overflow  <= 1'b0;
      end else if (accept_s) begin
         window_r  <= window;
         counter_r <= '0;
         ovf_int_r <= 1'b0;
         overflow  <= 1'b0;
         if (window == '0) begin
            count <= '0;
         end
      end else if ((state_r == ST_COUNT) && active) begin
         counter_r <= counter_nxt_s;
         ovf_int_r <= ovf_nxt_s;
         if (count_last_s) begin
            count    <= counter_nxt_s;
            overflow <= ovf_nxt_s;
         end
      end
   end

endmodule

// File: tb/tb_adder_ring_counter.sv
// Randomised bench for adder_ring_counter: a timeline model built from ring_in history
// predicts every output each cycle for a 32-bit and a 4-bit counter instance.
module tb_adder_ring_counter;
   localparam int SS = 2;
   localparam int ST = 4;

   logic        wb_clk_i = 1'b0;
   logic        rst_n = 1'b0;
   logic        active = 1'b1;
   logic        start = 1'b0;
   logic [31:0] window = 32'd0;
   logic        ring_in = 1'b0;

   logic        ring_en_a, busy_a, done_a, overflow_a;
   logic [31:0] count_a;
   logic        ring_en_b, busy_b, done_b, overflow_b;
   logic [3:0]  count_b;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rmode = 2;
   bit rstatic = 1'b0;

   // model state
   bit          hist [0:19999];
   bit          m_run = 1'b0;
   bit          m_done = 1'b0;
   logic [31:0] m_count_a = 32'd0;
   logic [3:0]  m_count_b = 4'd0;
   bit          m_ovf_b = 1'b0;
   int          m_e = 0;
   int          m_end = 0;

   int done_rise = -1;
   int en_cnt = 0;
   bit done_prev = 1'b0;

   always #5 wb_clk_i = ~wb_clk_i;

   adder_ring_counter #(.COUNT_W(32), .WIN_W(32), .SYNC_STAGES(2), .SETTLE_CYCLES(4)) dut_a (
      .wb_clk_i(wb_clk_i), .rst_n(rst_n), .active(active), .start(start), .window(window),
      .ring_in(ring_in), .ring_en(ring_en_a), .busy(busy_a), .done(done_a), .count(count_a),
      .overflow(overflow_a));

   adder_ring_counter #(.COUNT_W(4), .WIN_W(32), .SYNC_STAGES(2), .SETTLE_CYCLES(4)) dut_b (
      .wb_clk_i(wb_clk_i), .rst_n(rst_n), .active(active), .start(start), .window(window),
      .ring_in(ring_in), .ring_en(ring_en_b), .busy(busy_b), .done(done_b), .count(count_b),
      .overflow(overflow_b));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge wb_clk_i);
         #1;
      end
   endtask

   task automatic pulse_start(input logic [31:0] w);
      start = 1'b1;
      window = w;
      tick(1);
      start = 1'b0;
      window = 32'd0;
   endtask

   task automatic wait_done(input int limit);
      int n;
      n = 0;
      while (!done_a && n < limit) begin
         tick(1);
         n++;
      end
      chk("wait_done", 64'(done_a), 64'd1);
   endtask

   // Model step: outputs after edge cyc follow from inputs sampled at that edge.
   task automatic model_step();
      int raw;
      cyc = cyc + 1;
      hist[cyc] = ring_in;
      if (!rst_n) begin
         hist[cyc] = 1'b0;
         if (cyc >= 1) hist[cyc-1] = 1'b0;
         if (cyc >= 2) hist[cyc-2] = 1'b0;
         m_run = 1'b0; m_done = 1'b0;
         m_count_a = 32'd0; m_count_b = 4'd0; m_ovf_b = 1'b0;
      end else if (!active) begin
         m_run = 1'b0; m_done = 1'b0;
      end else if (m_run) begin
         if (cyc == m_end) begin
            raw = 0;
            for (int k = m_e + ST + 1; k <= m_end; k++)
               if (hist[k-SS] && !hist[k-SS-1]) raw++;
            m_run = 1'b0; m_done = 1'b1;
            m_count_a = 32'(raw);
            m_count_b = (raw > 15) ? 4'd15 : 4'(raw);
            m_ovf_b = (raw > 15);
         end
      end else if (start) begin
         m_ovf_b = 1'b0;
         if (window == 32'd0) begin
            m_done = 1'b1; m_count_a = 32'd0; m_count_b = 4'd0;
         end else begin
            m_run = 1'b1; m_done = 1'b0;
            m_e = cyc; m_end = cyc + ST + int'(window);
         end
      end
   endtask

   initial forever begin
      @(posedge wb_clk_i);
      model_step();
   end

   // ring_in patterns, changed just after each edge
   initial forever begin
      @(posedge wb_clk_i);
      #1;
      case (rmode)
         0: ring_in = rstatic;
         1: ring_in = ((cyc % 4) < 2);
         2: ring_in = ((cyc % 2) == 0);
         default: ring_in = 1'($urandom_range(0, 1));
      endcase
   end

   // per-cycle compare against the model, plus done-rise and ring_en monitors
   initial forever begin
      @(negedge wb_clk_i);
      if (cyc >= 1) begin
         chk("a_ring_en", 64'(ring_en_a), 64'(m_run));
         chk("a_busy", 64'(busy_a), 64'(m_run));
         chk("a_done", 64'(done_a), 64'(m_done));
         chk("a_count", 64'(count_a), 64'(m_count_a));
         chk("a_overflow", 64'(overflow_a), 64'd0);
         chk("b_ring_en", 64'(ring_en_b), 64'(m_run));
         chk("b_done", 64'(done_b), 64'(m_done));
         chk("b_count", 64'(count_b), 64'(m_count_b));
         chk("b_overflow", 64'(overflow_b), 64'(m_ovf_b));
      end
      if (done_a && !done_prev) done_rise = cyc;
      if (ring_en_a) en_cnt++;
      done_prev = done_a;
   end

   initial begin
      int t0;
      // reset held with ring toggling
      tick(50);
      chk("rst_ring_en", 64'(ring_en_a), 64'd0);
      chk("rst_busy", 64'(busy_a), 64'd0);
      chk("rst_done", 64'(done_a), 64'd0);
      chk("rst_count", 64'(count_a), 64'd0);
      chk("rst_overflow", 64'(overflow_a), 64'd0);
      rst_n = 1'b1;
      rmode = 1;
      tick(3);

      // window=100, edge every 4 cycles, ignored restart during COUNT
      t0 = cyc; en_cnt = 0; done_rise = -1;
      pulse_start(32'd100);
      tick(19);
      pulse_start(32'd7);
      wait_done(200);
      tick(1);
      chk("w100_done_time", 64'(done_rise), 64'(t0 + 105));
      chk("w100_count", 64'(count_a), 64'd25);
      chk("w100_overflow", 64'(overflow_a), 64'd0);
      chk("w100_ring_en_len", 64'(en_cnt), 64'd104);

      // abort at T+50 with a simultaneous start, then reset at T+60
      tick(2);
      t0 = cyc;
      pulse_start(32'd100);
      tick(49);
      active = 1'b0; start = 1'b1; window = 32'd5;
      tick(1);
      start = 1'b0; window = 32'd0;
      tick(1);
      chk("abort_busy", 64'(busy_a), 64'd0);
      chk("abort_done", 64'(done_a), 64'd0);
      chk("abort_count_held", 64'(count_a), 64'd25);
      active = 1'b1;
      tick(t0 + 60 - cyc);
      rst_n = 1'b0;
      tick(1);
      chk("reset_count", 64'(count_a), 64'd0);
      chk("reset_ring_en", 64'(ring_en_a), 64'd0);
      tick(2);
      rst_n = 1'b1;

      // window=0, then window=8 with ring static high
      tick(2);
      t0 = cyc; en_cnt = 0; done_rise = -1;
      pulse_start(32'd0);
      tick(3);
      chk("w0_done_time", 64'(done_rise), 64'(t0 + 1));
      chk("w0_count", 64'(count_a), 64'd0);
      chk("w0_no_ring_en", 64'(en_cnt), 64'd0);
      rmode = 0; rstatic = 1'b1;
      tick(3);
      pulse_start(32'd8);
      wait_done(50);
      chk("static_count", 64'(count_a), 64'd0);

      // saturation on the 4-bit instance
      rmode = 2;
      tick(2);
      pulse_start(32'd64);
      wait_done(100);
      chk("sat_count_b", 64'(count_b), 64'd15);
      chk("sat_overflow_b", 64'(overflow_b), 64'd1);
      chk("sat_count_a", 64'(count_a), 64'd32);

      // randomised traffic
      for (int r = 0; r < 40; r++) begin
         rmode = $urandom_range(0, 3);
         rstatic = 1'($urandom_range(0, 1));
         for (int c = 0; c < 60; c++) begin
            start = ($urandom_range(0, 9) == 0);
            window = 32'($urandom_range(0, 30));
            active = ($urandom_range(0, 39) != 0);
            rst_n = ($urandom_range(0, 149) != 0);
            tick(1);
         end
      end
      start = 1'b0; active = 1'b1; rst_n = 1'b1;
      tick(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
